// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline datapath and pipeline_sequencer.
//   master : sequencer side. It reads the hazard/command inputs and drives the
//            stage enables, flushes, status and counters.
//   slave  : datapath / driver side. This is the mirror of master.
// Signals:
//   start, finish_id, pc_src           : command and branch inputs
//   id_rs1, id_rs2, ex_mem_read, ex_rd : load-use hazard inputs
//   pc_en, if_id_en/flush, id_ex_en/flush, ex_mem_en, mem_wb_en : stage controls
//   running, done, cycle_count, stall_count                    : status
interface pipeline_sequencer_if #(
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 32
);
  logic                  start;
  logic                  finish_id;
  logic                  pc_src;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  pc_en;
  logic                  if_id_en;
  logic                  if_id_flush;
  logic                  id_ex_en;
  logic                  id_ex_flush;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  running;
  logic                  done;
  logic [CNT_W-1:0]      cycle_count;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    input  start, finish_id, pc_src, id_rs1, id_rs2, ex_mem_read, ex_rd,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, running, done, cycle_count, stall_count
  );

  modport slave (
    output start, finish_id, pc_src, id_rs1, id_rs2, ex_mem_read, ex_rd,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_en, running, done, cycle_count, stall_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Control block for a 5-stage pipeline (IF, ID, EX, MEM, WB).
// The block starts execution on a command. It produces the PC and inter-stage
// enables and flushes, resolves load-use stalls and taken-branch flushes, and
// drains the pipeline after a finish instruction leaves ID.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : pipeline_sequencer_if.master, which carries the command and hazard
//           inputs, the stage controls, the status flags and the counters
module pipeline_sequencer #(
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_sequencer_if.master   bus
);
  localparam int unsigned DRAIN_W = 4;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LD  = DRAIN_W'(DRAIN_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]     cycle_q, cycle_d;
  logic [CNT_W-1:0]     stall_q, stall_d;

  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  load_use;
  logic [CNT_W-1:0]      cycle_inc, stall_inc;

  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en, running, done;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;
  assign rd  = bus.ex_rd;

  // Register 0 is hard-wired, so a load that targets it never forces a stall.
  assign load_use = bus.ex_mem_read && (rd != '0) && ((rd == rs1) || (rd == rs2));

  // The counters saturate at all-ones.
  assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CNT_ONE;
  assign stall_inc = (stall_q == '1) ? stall_q : stall_q + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    cycle_d     = cycle_q;
    stall_d     = stall_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b1;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    running     = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (bus.start) begin
          state_d = S_RUN;
          cycle_d = '0;
          stall_d = '0;
        end
      end

      S_RUN: begin
        running   = 1'b1;
        cycle_d   = cycle_inc;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        id_ex_en  = 1'b1;
        if (bus.pc_src) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
        end else if (load_use) begin
          // IF/ID holds and is not cleared. A bubble goes into ID/EX.
          if_id_flush = 1'b0;
          stall_d     = stall_inc;
        end else begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b0;
          if (bus.finish_id) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LD;
          end
        end
      end

      S_DRAIN: begin
        running   = 1'b1;
        cycle_d   = cycle_inc;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        drain_d   = drain_q - DRAIN_ONE;
        if (drain_q == DRAIN_ONE) state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.running     = running;
  assign bus.done        = done;
  assign bus.cycle_count = cycle_q;
  assign bus.stall_count = stall_q;
endmodule

// File: tb/tb_pipeline_sequencer.sv
module tb_pipeline_sequencer;
  localparam int unsigned DRAIN = 3;
  localparam longint unsigned CMAX = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.REG_ADDR_W(4), .CNT_W(32)) bus ();

  pipeline_sequencer #(.REG_ADDR_W(4), .DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ctl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, running, done}
  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] cyc;
    logic [31:0] stl;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model, kept as phases and counts of remaining work.
  bit              m_active = 0;
  bit              m_done   = 0;
  int              m_drain_left = 0;
  longint unsigned m_cyc = 0;
  longint unsigned m_stl = 0;

  task automatic step(input bit st, input bit fin, input bit br,
                      input logic [3:0] rs1, input logic [3:0] rs2,
                      input bit mr, input logic [3:0] rd, input bit rst);
    exp_t e;
    bit   hazard;
    reset           = rst;
    bus.start       = st;
    bus.finish_id   = fin;
    bus.pc_src      = br;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.ex_mem_read = mr;
    bus.ex_rd       = rd;
    if (rst) begin
      m_active = 0; m_done = 0; m_drain_left = 0; m_cyc = 0; m_stl = 0;
    end
    hazard = mr && rd != 0 && (rd == rs1 || rd == rs2);
    e.cyc = 32'(m_cyc);
    e.stl = 32'(m_stl);
    if (!m_active)             e.ctl = {7'b0010100, 1'b0, m_done};
    else if (m_drain_left > 0) e.ctl = 9'b001111110;
    else if (br)               e.ctl = 9'b111111110;
    else if (hazard)           e.ctl = 9'b000111110;
    else                       e.ctl = 9'b110101110;
    exp_q.push_back(e);
    // The state advances at the coming edge.
    if (!rst) begin
      if (!m_active) begin
        if (st) begin m_active = 1; m_done = 0; m_cyc = 0; m_stl = 0; end
      end else begin
        if (m_cyc < CMAX) m_cyc++;
        if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) begin m_active = 0; m_done = 1; end
        end else if (br) begin
        end else if (hazard) begin
          if (m_stl < CMAX) m_stl++;
        end else if (fin) begin
          m_drain_left = DRAIN;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input bit st, input bit fin);
    step(st, fin, 1'b0, 4'd1, 4'd2, 1'b0, 4'd5, 1'b0);
  endtask

  // Monitor: compares the DUT against the oldest pending expectation on each falling edge.
  initial begin
    exp_t  e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        act = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
               bus.ex_mem_en, bus.mem_wb_en, bus.running, bus.done};
        if (act !== e.ctl) begin
          n_bad++;
          $display("FAIL ctl @%0t: got %b want %b", $time, act, e.ctl);
        end
        if (bus.cycle_count !== e.cyc) begin
          n_bad++;
          $display("FAIL cycle_count @%0t: got %0d want %0d", $time, bus.cycle_count, e.cyc);
        end
        if (bus.stall_count !== e.stl) begin
          n_bad++;
          $display("FAIL stall_count @%0t: got %0d want %0d", $time, bus.stall_count, e.stl);
        end
      end
    end
  end

  initial begin
    bus.start = 0; bus.finish_id = 0; bus.pc_src = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    quiet(0, 0);                                  // idle after reset
    quiet(1, 0);                                  // start
    repeat (5) quiet(0, 0);                       // cycle_count reaches 5
    step(0, 0, 0, 4'd1, 4'd3, 1, 4'd3, 0);        // load-use on rs2
    step(0, 0, 0, 4'd0, 4'd0, 1, 4'd0, 0);        // r0 never stalls
    step(0, 1, 1, 4'd3, 4'd3, 1, 4'd3, 0);        // branch dominates finish and hazard
    quiet(0, 0);
    step(0, 1, 0, 4'd7, 4'd2, 1, 4'd7, 0);        // stall dominates finish
    quiet(0, 1);                                  // finish -> drain
    step(1, 0, 1, 4'd4, 4'd4, 1, 4'd4, 0);        // drain ignores everything
    quiet(1, 0);
    quiet(0, 0);
    quiet(0, 0);                                  // done, counters frozen
    quiet(0, 0);
    quiet(1, 0);                                  // restart
    quiet(0, 0);
    quiet(0, 1);
    quiet(0, 0);                                  // in drain
    step(0, 0, 0, 0, 0, 0, 0, 1);                 // async reset mid-drain
    quiet(0, 0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(7) == 0,
           4'($urandom_range(3)), 4'($urandom_range(3)), $urandom_range(2) == 0,
           4'($urandom_range(3)), $urandom_range(63) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
